// File: rtl/rgb_line_arb.sv
// rgb_line_arb: two-source RGB line arbiter.
// Grants one source for a whole line of LINE_W_P pixels and forwards its
// valid/ready/data combinationally to a single downstream port. An idle
// bubble of one cycle separates consecutive lines.
// Build option: define RGB_LINE_ARB_FIXED_PRIO_EN for fixed priority
// (source 0 wins every tie); the default build uses round-robin.
module rgb_line_arb #(
  parameter int WIDTH_P  = 8,
  parameter int LINE_W_P = 640
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  // source 0
  input  logic                 s0_valid_i,
  output logic                 s0_ready_o,
  input  logic [3*WIDTH_P-1:0] s0_rgb_i,
  // source 1
  input  logic                 s1_valid_i,
  output logic                 s1_ready_o,
  input  logic [3*WIDTH_P-1:0] s1_rgb_i,
  // toward the grayscale converter
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [3*WIDTH_P-1:0] m_rgb_o,
  output logic                 m_src_o,
  output logic                 m_eol_o
);

  // Index of the last pixel of a line, compared against the 16-bit counter.
  localparam logic [15:0] LAST_IDX = 16'(LINE_W_P - 1);

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_grant;
  logic [15:0]         r_cnt;
`ifndef RGB_LINE_ARB_FIXED_PRIO_EN
  logic                r_last;
`endif

  logic                w_any;
  logic                w_sel;
  logic                w_lock;
  logic                w_gvalid;
  logic [3*WIDTH_P-1:0] w_grgb;
  logic                w_xfer;
  logic                w_last_pix;

  // Source selection taken on the IDLE->LOCK edge.
  always_comb begin
    w_any = s0_valid_i | s1_valid_i;
    if (s0_valid_i && s1_valid_i) begin
`ifdef RGB_LINE_ARB_FIXED_PRIO_EN
      w_sel = 1'b0;
`else
      // Tie: serve whichever source did not own the previous line.
      w_sel = ~r_last;
`endif
    end else begin
      // Single requester (or none, in which case the value is unused).
      w_sel = s1_valid_i;
    end
  end

  // Combinational datapath from the granted source; everything is forced
  // low while reset is asserted so outputs are clean during reset.
  always_comb begin
    w_lock     = (r_state == LOCK) && !rst_i;
    w_gvalid   = r_grant ? s1_valid_i : s0_valid_i;
    w_grgb     = r_grant ? s1_rgb_i   : s0_rgb_i;
    w_last_pix = (r_cnt == LAST_IDX);

    m_valid_o  = w_lock & w_gvalid;
    m_rgb_o    = w_lock ? w_grgb : '0;
    s0_ready_o = w_lock & ~r_grant & m_ready_i;
    s1_ready_o = w_lock &  r_grant & m_ready_i;
    m_eol_o    = m_valid_o & w_last_pix;
    // Grant register already holds its value through IDLE.
    m_src_o    = r_grant & ~rst_i;
    w_xfer     = m_valid_o & m_ready_i;
  end

  // Arbitration FSM, grant register and pixel counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_grant <= 1'b0;
      r_cnt   <= '0;
`ifndef RGB_LINE_ARB_FIXED_PRIO_EN
      // Pretend source 1 was served last so source 0 wins the first tie.
      r_last  <= 1'b1;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_cnt <= '0;
          if (w_any) begin
            r_state <= LOCK;
            r_grant <= w_sel;
          end
        end
        LOCK: begin
          // A stalled or absent pixel simply leaves the counter alone;
          // the grant is only released by the end-of-line transfer.
          if (w_xfer) begin
            if (w_last_pix) begin
              r_state <= IDLE;
              r_cnt   <= '0;
`ifndef RGB_LINE_ARB_FIXED_PRIO_EN
              r_last  <= r_grant;
`endif
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_line_arb.sv
// Testbench for rgb_line_arb (LINE_W_P=4, WIDTH_P=8).
// A driver issues directed and random stimulus and pushes the expected
// per-cycle outputs from a line-level reference model into a queue; a
// monitor pops and compares on the falling edge. Completed lines seen at
// the output are also compared against the model's line log.
module tb_rgb_line_arb;

  localparam int W = 8;
  localparam int L = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          s0_valid, s1_valid;
  logic          s0_ready, s1_ready;
  logic [3*W-1:0] s0_rgb, s1_rgb;
  logic          m_valid, m_ready;
  logic [3*W-1:0] m_rgb;
  logic          m_src, m_eol;

  rgb_line_arb #(.WIDTH_P(W), .LINE_W_P(L)) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .s0_valid_i(s0_valid),
    .s0_ready_o(s0_ready),
    .s0_rgb_i  (s0_rgb),
    .s1_valid_i(s1_valid),
    .s1_ready_o(s1_ready),
    .s1_rgb_i  (s1_rgb),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_rgb_o   (m_rgb),
    .m_src_o   (m_src),
    .m_eol_o   (m_eol)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          v;
    logic [3*W-1:0] rgb;
    logic          src;
    logic          eol;
    logic          r0;
    logic          r1;
  } exp_t;

  exp_t q[$];
  int   mdl_lines[$];
  int   dut_lines[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model state: who owns the line (-1 = nobody), how many
  // pixels of it have been delivered, who owned the previous line, and
  // the source index the output last reported.
  int owner    = -1;
  int pos      = 0;
  int last     = 1;
  int src_hold = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef RGB_LINE_ARB_FIXED_PRIO_EN
      return 0;
`else
      return 1 - last;
`endif
    end
    return v0 ? 0 : 1;
  endfunction

  // One clock cycle: drive inputs, predict outputs, advance the model.
  task automatic step(input logic r, input logic v0, input logic v1,
                      input logic [3*W-1:0] c0, input logic [3*W-1:0] c1,
                      input logic rdy);
    exp_t e;
    logic vv;
    rst = r; s0_valid = v0; s1_valid = v1; s0_rgb = c0; s1_rgb = c1; m_ready = rdy;
    vv    = 1'b0;
    e.v   = 1'b0; e.rgb = '0; e.eol = 1'b0; e.r0 = 1'b0; e.r1 = 1'b0;
    e.src = r ? 1'b0 : src_hold[0];
    if (!r && owner >= 0) begin
      vv    = (owner == 0) ? v0 : v1;
      e.v   = vv;
      e.rgb = (owner == 0) ? c0 : c1;
      e.src = owner[0];
      e.eol = vv && (pos == L - 1);
      e.r0  = (owner == 0) && rdy;
      e.r1  = (owner == 1) && rdy;
    end
    q.push_back(e);
    @(posedge clk);
    if (r) begin
      owner = -1; pos = 0; last = 1; src_hold = 0;
    end else if (owner < 0) begin
      if (v0 || v1) begin
        owner    = pick(v0, v1);
        src_hold = owner;
        pos      = 0;
      end
    end else if (vv && rdy) begin
      if (pos == L - 1) begin
        mdl_lines.push_back(owner);
        last  = owner;
        owner = -1;
        pos   = 0;
      end else begin
        pos++;
      end
    end
    #1;
  endtask

  // Monitor: compare every cycle against the next expected record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("m_valid", 32'(m_valid),  32'(e.v));
        chk("m_rgb",   32'(m_rgb),    32'(e.rgb));
        chk("m_src",   32'(m_src),    32'(e.src));
        chk("m_eol",   32'(m_eol),    32'(e.eol));
        chk("s0_ready",32'(s0_ready), 32'(e.r0));
        chk("s1_ready",32'(s1_ready), 32'(e.r1));
        if (m_valid && m_ready && m_eol) dut_lines.push_back(int'(m_src));
      end
    end
  end

  // Driver: directed scenarios followed by random traffic.
  initial begin
    int base;
    int w;
    int nmin;
    rst = 1'b1; s0_valid = 1'b0; s1_valid = 1'b0;
    s0_rgb = '0; s1_rgb = '0; m_ready = 1'b0;
    @(posedge clk); #1;

    // Reset held for a few cycles: all outputs low.
    repeat (3) step(1, 0, 0, 24'h0, 24'h0, 0);

    // Single source streaming: bubble, 4 pixels from s0, bubble.
    repeat (6) step(0, 1, 0, 24'h102030, 24'h0, 1);
    chk("single_line_count", 32'(dut_lines.size()), 32'd1);
    if (dut_lines.size() > 0) chk("single_line_src", 32'(dut_lines[0]), 32'd0);

    // Both sources always valid after reset: four lines.
    step(1, 0, 0, 24'h0, 24'h0, 0);
    base = dut_lines.size();
    for (int i = 0; i < 20; i++)
      step(0, 1, 1, 24'h000100 + 24'(i), 24'h110000 + 24'(i), 1);
    chk("tie_line_count", 32'(dut_lines.size() - base), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (base + i < dut_lines.size()) begin
`ifdef RGB_LINE_ARB_FIXED_PRIO_EN
        chk("tie_line_src", 32'(dut_lines[base+i]), 32'd0);
`else
        chk("tie_line_src", 32'(dut_lines[base+i]), 32'(i % 2));
`endif
      end
    end

    // s0 owns the line, drops valid after pixel 2 while s1 keeps asking.
    step(1, 0, 0, 24'h0, 24'h0, 0);
    step(0, 1, 1, 24'hA00000, 24'hB00000, 1);
    step(0, 1, 1, 24'hA00001, 24'hB00001, 1);
    step(0, 1, 1, 24'hA00002, 24'hB00002, 1);
    repeat (5) step(0, 0, 1, 24'hA0FFFF, 24'hB0FFFF, 1);
    step(0, 1, 1, 24'hA00003, 24'hB00003, 1);
    step(0, 1, 1, 24'hA00004, 24'hB00004, 1);
    step(0, 0, 0, 24'h0, 24'h0, 1);

    // Downstream stalls for 3 cycles on pixel 3.
    step(1, 0, 0, 24'h0, 24'h0, 0);
    step(0, 1, 0, 24'h000001, 24'h0, 1);
    step(0, 1, 0, 24'h000002, 24'h0, 1);
    step(0, 1, 0, 24'h000003, 24'h0, 1);
    repeat (3) step(0, 1, 0, 24'h000044, 24'h0, 0);
    step(0, 1, 0, 24'h000044, 24'h0, 1);
    step(0, 1, 0, 24'h000055, 24'h0, 1);
    step(0, 0, 0, 24'h0, 24'h0, 1);

    // Reset in the middle of a line, then a tie that must go to s0.
    step(1, 0, 0, 24'h0, 24'h0, 0);
    step(0, 1, 0, 24'h123456, 24'h0, 1);
    step(0, 1, 0, 24'h123457, 24'h0, 1);
    step(0, 1, 0, 24'h123458, 24'h0, 1);
    step(1, 1, 1, 24'h123459, 24'h654321, 1);
    base = dut_lines.size();
    repeat (5) step(0, 1, 1, 24'(32'h00C0FFEE), 24'h654321, 1);
    chk("post_reset_line_count", 32'(dut_lines.size() - base), 32'd1);
    if (dut_lines.size() > base) chk("post_reset_src", 32'(dut_lines[base]), 32'd0);

    // Random traffic with occasional resets.
    for (int i = 0; i < 2500; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0),
           24'($urandom), 24'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    // Let the monitor drain, bounded.
    w = 0;
    while (q.size() > 0 && w < 10) begin
      @(posedge clk);
      w++;
    end
    chk("queue_drained", 32'(q.size()), 32'd0);

    // Completed lines observed at the output versus the model's log.
    chk("line_log_len", 32'(dut_lines.size()), 32'(mdl_lines.size()));
    nmin = (dut_lines.size() < mdl_lines.size()) ? dut_lines.size() : mdl_lines.size();
    for (int i = 0; i < nmin; i++)
      chk("line_log_src", 32'(dut_lines[i]), 32'(mdl_lines[i]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
